// File: rtl/rmii_rx_deframer_if.sv
// Byte-stream bus from the RMII deframer to the GMII-style receive parser.
interface rmii_rx_deframer_if;
  logic [7:0]  o_rxd;
  logic        o_rx_stb;
  logic        o_rx_dv;
  logic        o_rx_er;
  logic        o_frame_end;
  logic [10:0] o_frame_len;
  logic        o_dribble;
  logic        o_oversize;

  modport master (
    output o_rxd, o_rx_stb, o_rx_dv, o_rx_er, o_frame_end, o_frame_len, o_dribble, o_oversize
  );

  modport slave (
    input o_rxd, o_rx_stb, o_rx_dv, o_rx_er, o_frame_end, o_frame_len, o_dribble, o_oversize
  );
endinterface

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: dibits at 50 MHz in, strobed GMII bytes out, with preamble/SFD
// detection, CRS_DV toggle handling and frame length / dribble / oversize reporting.
module rmii_rx_deframer #(
  parameter int unsigned PREAMBLE_MIN    = 8,
  parameter int unsigned MAX_FRAME_BYTES = 1536
) (
  input  logic                      clk_rmii,
  input  logic                      rstn,
  input  logic [1:0]                i_rxd,
  input  logic                      i_crs_dv,
  input  logic                      i_rx_er,
  rmii_rx_deframer_if.master        rx_if
);

  localparam logic [3:0]  PreMin   = 4'(PREAMBLE_MIN);
  localparam logic [10:0] MaxBytes = 11'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StPre, StData} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rxd_d1_q;
  logic        crs_d1_q, er_d1_q;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        err_acc_q, err_acc_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;

  logic [7:0]  rxd_q, rxd_d;
  logic        stb_q, stb_d;
  logic        dv_q, dv_d;
  logic        er_q, er_d;
  logic        fend_q, fend_d;
  logic [10:0] len_q, len_d;
  logic        drib_q, drib_d;
  logic        over_q, over_d;

  logic        carrier_end;
  logic [7:0]  byte_asm;

  // A lone low CRS_DV sample is the RMII toggle; two consecutive lows end the carrier.
  assign carrier_end = ~crs_d1_q & ~i_crs_dv;
  assign byte_asm    = {rxd_d1_q, shreg_q[7:2]};

  // Next-state and output decode; the FSM consumes the d1 stage.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    phase_d    = phase_q;
    shreg_d    = shreg_q;
    err_acc_d  = err_acc_q;
    byte_cnt_d = byte_cnt_q;
    rxd_d      = rxd_q;
    dv_d       = dv_q;
    er_d       = er_q;
    len_d      = len_q;
    stb_d      = 1'b0;
    fend_d     = 1'b0;
    drib_d     = 1'b0;
    over_d     = 1'b0;

    unique case (state_q)
      StWaitIdle: begin
        if (carrier_end) state_d = StIdle;
      end
      StIdle: begin
        if (crs_d1_q) begin
          if (rxd_d1_q == 2'b01) begin
            state_d   = StPre;
            pre_cnt_d = 4'd1;
          end else if (rxd_d1_q != 2'b00) begin
            state_d = StWaitIdle;
          end
        end
      end
      StPre: begin
        if (carrier_end) begin
          state_d = StIdle;
        end else if (rxd_d1_q == 2'b01) begin
          if (pre_cnt_q != 4'hf) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (rxd_d1_q == 2'b11 && pre_cnt_q >= PreMin) begin
          stb_d      = 1'b1;
          rxd_d      = 8'hd5;
          dv_d       = 1'b1;
          er_d       = 1'b0;
          state_d    = StData;
          phase_d    = 2'd0;
          byte_cnt_d = 11'd0;
          err_acc_d  = 1'b0;
        end else begin
          state_d = StWaitIdle;
        end
      end
      StData: begin
        if (carrier_end) begin
          // Terminating strobe; any partial byte is dropped and flagged as dribble.
          stb_d   = 1'b1;
          rxd_d   = 8'h00;
          dv_d    = 1'b0;
          er_d    = 1'b0;
          fend_d  = 1'b1;
          len_d   = byte_cnt_q;
          drib_d  = (phase_q != 2'd0);
          state_d = StIdle;
        end else begin
          shreg_d   = byte_asm;
          phase_d   = phase_q + 2'd1;
          err_acc_d = err_acc_q | er_d1_q;
          if (phase_q == 2'd3) begin
            err_acc_d = 1'b0;
            stb_d     = 1'b1;
            if (byte_cnt_q == MaxBytes) begin
              // Byte slot past the limit becomes the terminating strobe.
              rxd_d   = 8'h00;
              dv_d    = 1'b0;
              er_d    = 1'b0;
              fend_d  = 1'b1;
              over_d  = 1'b1;
              len_d   = MaxBytes;
              state_d = StWaitIdle;
            end else begin
              rxd_d      = byte_asm;
              dv_d       = 1'b1;
              er_d       = err_acc_q | er_d1_q;
              byte_cnt_d = byte_cnt_q + 11'd1;
            end
          end
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  // Input stage, FSM state and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      state_q    <= StWaitIdle;
      rxd_d1_q   <= 2'b00;
      crs_d1_q   <= 1'b0;
      er_d1_q    <= 1'b0;
      pre_cnt_q  <= 4'd0;
      phase_q    <= 2'd0;
      shreg_q    <= 8'h00;
      err_acc_q  <= 1'b0;
      byte_cnt_q <= 11'd0;
      rxd_q      <= 8'h00;
      stb_q      <= 1'b0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      fend_q     <= 1'b0;
      len_q      <= 11'd0;
      drib_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_d1_q   <= i_rxd;
      crs_d1_q   <= i_crs_dv;
      er_d1_q    <= i_rx_er;
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      err_acc_q  <= err_acc_d;
      byte_cnt_q <= byte_cnt_d;
      rxd_q      <= rxd_d;
      stb_q      <= stb_d;
      dv_q       <= dv_d;
      er_q       <= er_d;
      fend_q     <= fend_d;
      len_q      <= len_d;
      drib_q     <= drib_d;
      over_q     <= over_d;
    end
  end

  assign rx_if.o_rxd       = rxd_q;
  assign rx_if.o_rx_stb    = stb_q;
  assign rx_if.o_rx_dv     = dv_q;
  assign rx_if.o_rx_er     = er_q;
  assign rx_if.o_frame_end = fend_q;
  assign rx_if.o_frame_len = len_q;
  assign rx_if.o_dribble   = drib_q;
  assign rx_if.o_oversize  = over_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Self-checking bench: per-cycle dibit streams, compared strobe-by-strobe against a
// stream-parsing reference model.
module tb_rmii_rx_deframer;

  localparam int PreMin   = 8;
  localparam int MaxBytes = 4;
  localparam int MaxLen   = 512;

  logic       clk_rmii = 1'b0;
  logic       rstn     = 1'b0;
  logic [1:0] i_rxd    = 2'b00;
  logic       i_crs_dv = 1'b0;
  logic       i_rx_er  = 1'b0;

  rmii_rx_deframer_if rx_if ();

  rmii_rx_deframer #(
    .PREAMBLE_MIN    (PreMin),
    .MAX_FRAME_BYTES (MaxBytes)
  ) dut (
    .clk_rmii (clk_rmii),
    .rstn     (rstn),
    .i_rxd    (i_rxd),
    .i_crs_dv (i_crs_dv),
    .i_rx_er  (i_rx_er),
    .rx_if    (rx_if)
  );

  always #10 clk_rmii = ~clk_rmii;

  typedef struct {
    int          cyc;
    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic        fend;
    logic [10:0] len;
    logic        drib;
    logic        over;
  } stb_t;

  stb_t exp_q[$];
  stb_t obs_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [1:0] s_rxd [MaxLen];
  logic       s_crs [MaxLen];
  logic       s_er  [MaxLen];
  int         n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stream construction ----------------
  task automatic push(input logic [1:0] d, input logic c, input logic e);
    if (n < MaxLen) begin
      s_rxd[n] = d;
      s_crs[n] = c;
      s_er[n]  = e;
      n++;
    end
  endtask

  task automatic push_idle(input int k);
    for (int q = 0; q < k; q++) push(2'b00, 1'b0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [3:0] crs_m, input logic [3:0] er_m);
    for (int q = 0; q < 4; q++) push(b[2*q +: 2], crs_m[q], er_m[q]);
  endtask

  // 28 preamble dibits plus SFD octet 01,01,01,11.
  task automatic push_head();
    push_idle(2);
    for (int q = 0; q < 31; q++) push(2'b01, 1'b1, 1'b0);
    push(2'b11, 1'b1, 1'b0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic crs_at(input int k);
    return (k < n) ? s_crs[k] : 1'b0;
  endfunction

  function automatic logic end_at(input int k);
    return !crs_at(k) && !crs_at(k + 1);
  endfunction

  function automatic int next_end(input int k);
    int m = k;
    while (!end_at(m)) m++;
    return m;
  endfunction

  task automatic exp_push(input int cyc, input logic [7:0] rxd, input logic dv, input logic er,
                          input logic fend, input int len, input logic drib, input logic over);
    stb_t s;
    s.cyc = cyc; s.rxd = rxd; s.dv = dv; s.er = er; s.fend = fend;
    s.len = 11'(len); s.drib = drib; s.over = over;
    exp_q.push_back(s);
  endtask

  // Parse the stream from 'start'; an output for the dibit at index k appears in cycle k+1.
  task automatic model_scan(input int start, input logic blocked);
    int i = blocked ? next_end(start) + 1 : start;
    while (i < n) begin
      int j, k, e, b;
      logic done;
      if (!s_crs[i] || s_rxd[i] == 2'b00) begin i++; continue; end
      if (s_rxd[i] != 2'b01) begin i = next_end(i + 1) + 1; continue; end
      j = i;
      while (!end_at(j) && s_rxd[j] == 2'b01) j++;
      if (end_at(j)) begin i = j + 1; continue; end
      if (!(s_rxd[j] == 2'b11 && (j - i) >= PreMin)) begin i = next_end(j + 1) + 1; continue; end
      exp_push(j + 1, 8'hd5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      k = j + 1;
      e = next_end(k);
      b = 0;
      done = 1'b0;
      for (int c = 0; k + 4 * c + 3 < e; c++) begin
        int last = k + 4 * c + 3;
        if (b == MaxBytes) begin
          exp_push(last + 1, 8'h00, 1'b0, 1'b0, 1'b1, b, 1'b0, 1'b1);
          i = next_end(last + 1) + 1;
          done = 1'b1;
          break;
        end
        exp_push(last + 1, {s_rxd[last], s_rxd[last-1], s_rxd[last-2], s_rxd[last-3]}, 1'b1,
                 s_er[last] | s_er[last-1] | s_er[last-2] | s_er[last-3], 1'b0, 0, 1'b0, 1'b0);
        b++;
      end
      if (!done) begin
        exp_push(e + 1, 8'h00, 1'b0, 1'b0, 1'b1, b, ((e - k) % 4) != 0, 1'b0);
        i = e + 1;
      end
    end
  endtask

  // ---------------- episode runner ----------------
  task automatic run_episode(input string name, input int reset_at);
    exp_q.delete();
    obs_q.delete();
    model_scan(0, 1'b0);
    if (reset_at >= 0) begin
      for (int q = exp_q.size() - 1; q >= 0; q--)
        if (exp_q[q].cyc >= reset_at) exp_q.delete(q);
      model_scan(reset_at + 1, crs_at(reset_at + 1));
    end

    for (int t = 0; t <= n + 1; t++) begin
      @(negedge clk_rmii);
      if (t > 0 && rx_if.o_rx_stb) begin
        stb_t o;
        o.cyc = t - 1; o.rxd = rx_if.o_rxd; o.dv = rx_if.o_rx_dv; o.er = rx_if.o_rx_er;
        o.fend = rx_if.o_frame_end; o.len = rx_if.o_frame_len;
        o.drib = rx_if.o_dribble; o.over = rx_if.o_oversize;
        obs_q.push_back(o);
      end
      if (reset_at >= 0 && t == reset_at + 1) begin
        check_val({name, ".rst_outs"},
                  32'({rx_if.o_rxd, rx_if.o_rx_stb, rx_if.o_rx_dv, rx_if.o_rx_er,
                       rx_if.o_frame_end, rx_if.o_frame_len, rx_if.o_dribble,
                       rx_if.o_oversize}), 32'd0);
      end
      rstn = !(reset_at >= 0 && t == reset_at);
      if (t < n) begin
        i_rxd = s_rxd[t]; i_crs_dv = s_crs[t]; i_rx_er = s_er[t];
      end else begin
        i_rxd = 2'b00; i_crs_dv = 1'b0; i_rx_er = 1'b0;
      end
    end

    check_val({name, ".count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int q = 0; q < obs_q.size() && q < exp_q.size(); q++) begin
      string p = $sformatf("%s[%0d]", name, q);
      check_val({p, ".cyc"},  32'(obs_q[q].cyc),  32'(exp_q[q].cyc));
      check_val({p, ".rxd"},  32'(obs_q[q].rxd),  32'(exp_q[q].rxd));
      check_val({p, ".dv"},   32'(obs_q[q].dv),   32'(exp_q[q].dv));
      check_val({p, ".fend"}, 32'(obs_q[q].fend), 32'(exp_q[q].fend));
      check_val({p, ".drib"}, 32'(obs_q[q].drib), 32'(exp_q[q].drib));
      check_val({p, ".over"}, 32'(obs_q[q].over), 32'(exp_q[q].over));
      if (exp_q[q].dv)   check_val({p, ".er"},  32'(obs_q[q].er),  32'(exp_q[q].er));
      if (exp_q[q].fend) check_val({p, ".len"}, 32'(obs_q[q].len), 32'(exp_q[q].len));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rstn = 1'b0;
    repeat (2) @(posedge clk_rmii);
    @(negedge clk_rmii);
    check_val("reset.stb",  32'(rx_if.o_rx_stb),    32'd0);
    check_val("reset.rxd",  32'(rx_if.o_rxd),       32'd0);
    check_val("reset.dv",   32'(rx_if.o_rx_dv),     32'd0);
    check_val("reset.fend", 32'(rx_if.o_frame_end), 32'd0);
    check_val("reset.len",  32'(rx_if.o_frame_len), 32'd0);
    check_val("reset.flags",
              32'({rx_if.o_rx_er, rx_if.o_dribble, rx_if.o_oversize}), 32'd0);
    rstn = 1'b1;

    n = 0; push_head();
    push_byte(8'h12, 4'hf, 4'h0); push_byte(8'h34, 4'hf, 4'h0); push_idle(4);
    run_episode("nominal", -1);

    n = 0; push_head();
    push_byte(8'h12, 4'hf, 4'h0); push_byte(8'h34, 4'b1010, 4'h0); push_idle(4);
    run_episode("toggle", -1);

    n = 0; push_head();
    push_byte(8'h12, 4'hf, 4'h0); push_byte(8'h34, 4'hf, 4'h0);
    push(2'b11, 1'b1, 1'b0); push(2'b10, 1'b1, 1'b0); push_idle(4);
    run_episode("dribble", -1);

    n = 0; push_idle(2);
    for (int q = 0; q < 3; q++) push(2'b01, 1'b1, 1'b0);
    push(2'b11, 1'b1, 1'b0); push_byte(8'h9c, 4'hf, 4'h0); push_idle(3);
    push_head(); push_byte(8'h5a, 4'hf, 4'h0); push_idle(4);
    run_episode("short_pre", -1);

    n = 0; push_idle(2); push(2'b10, 1'b1, 1'b0);
    for (int q = 0; q < 12; q++) push(2'b01, 1'b1, 1'b0);
    push(2'b11, 1'b1, 1'b0); push_byte(8'ha5, 4'hf, 4'h0); push_idle(3);
    push_head(); push_byte(8'h77, 4'hf, 4'h0); push_idle(4);
    run_episode("false_carrier", -1);

    n = 0; push_head();
    push_byte(8'h11, 4'hf, 4'h0); push_byte(8'h22, 4'hf, 4'b0100);
    push_byte(8'h33, 4'hf, 4'h0); push_idle(4);
    run_episode("rx_er", -1);

    n = 0; push_head();
    for (int q = 1; q <= 6; q++) push_byte(8'(q * 17), 4'hf, 4'h0);
    push_idle(4);
    run_episode("oversize", -1);

    n = 0; push_head();
    push_byte(8'hab, 4'hf, 4'h0); push_byte(8'hcd, 4'hf, 4'h0);
    r = n + 1;
    push_byte(8'hef, 4'hf, 4'h0); push_byte(8'h01, 4'hf, 4'h0); push_idle(4);
    push_head(); push_byte(8'h42, 4'hf, 4'h0); push_idle(4);
    run_episode("reset_mid", r);

    for (int ep = 0; ep < 30; ep++) begin
      int   pl, nb, nx;
      logic prev;
      n = 0;
      push_idle(2 + $urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) push(2'($urandom_range(0, 3)), 1'b1, 1'b0);
      pl = $urandom_range(2, 20);
      for (int q = 0; q < pl; q++) begin
        if ($urandom_range(0, 39) == 0) push(2'($urandom_range(0, 3)), 1'b1, 1'($urandom));
        else push(2'b01, 1'b1, 1'($urandom));
      end
      push(2'b11, 1'b1, 1'b0);
      nb = $urandom_range(0, 6);
      nx = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      prev = 1'b1;
      for (int q = 0; q < nb * 4 + nx; q++) begin
        logic c = !(prev && $urandom_range(0, 7) == 0);
        push(2'($urandom_range(0, 3)), c, $urandom_range(0, 15) == 0);
        prev = c;
      end
      push_idle(3);
      run_episode($sformatf("rand%0d", ep), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
